// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and default sizing for the mux scan controller.
//   state_t      : scan FSM state encoding (IDLE, SETTLE, CAPTURE)
//   NUM_CH_DEF   : default number of mux channels scanned
//   SEL_W_DEF    : default select width (clog2 of NUM_CH_DEF)
//   DWELL_W_DEF  : default width of the dwell / settle counter
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETTLE  = 2'b01,
        CAPTURE = 2'b10
    } state_t;

    localparam int NUM_CH_DEF  = 4;
    localparam int SEL_W_DEF   = 2;
    localparam int DWELL_W_DEF = 4;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_dwell_cnt.sv
// -----------------------------------------------------------------------------
// mux_scan_dwell_cnt
// Settle-time counter used by the scan controller. Counts up while enabled and
// flags when the count equals the latched limit.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (count -> 0)
//   clear  : synchronous clear, has priority over enable
//   enable : increment the count this cycle
//   limit  : compare value (latched dwell)
//   count  : current count (registered)
//   hit    : count == limit
// -----------------------------------------------------------------------------
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int W = DWELL_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    // Settle counter register; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

    assign hit = (count == limit);

endmodule : mux_scan_dwell_cnt

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Sequencer that walks a shared 4:1 bit mux through channels 0..NUM_CH-1,
// waits a programmable settle time on each, captures the mux output bit and
// presents the assembled sample vector with a one-cycle valid pulse.
//
// Optional feature macro: MUX_SCAN_CONT_EN
//   When defined, adds input 'cont'. If cont=1 at the final capture of a scan
//   the controller restarts on channel 0 immediately (continuous framing).
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : scan request, only looked at in IDLE
//   dwell      : extra settle cycles per channel, latched when a scan starts
//   mux_out    : output bit of the downstream mux
//   cont       : (MUX_SCAN_CONT_EN only) continue into another frame
//   sel        : registered mux select
//   sample_vec : last completed scan, bit k = channel k
//   valid      : one-cycle pulse when sample_vec updates
//   busy       : high while a scan is in progress
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
`ifdef MUX_SCAN_CONT_EN
    input  logic               cont,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_CH-1:0]  sample_vec,
    output logic               valid,
    output logic               busy
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    state_t               state_r;
    logic [NUM_CH-1:0]    shadow_r;
    logic [DWELL_W-1:0]   dwell_q_r;

    logic [DWELL_W-1:0]   cnt_s;
    logic                 hit_s;
    logic                 cnt_clear_s;
    logic                 cnt_enable_s;
    logic                 settle_done_s;
    logic                 repeat_s;
    logic [NUM_CH-1:0]    capture_vec_s;

    mux_scan_dwell_cnt #(
        .W (DWELL_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .limit  (dwell_q_r),
        .count  (cnt_s),
        .hit    (hit_s)
    );

    // The counter can never legitimately pass dwell_q; treating an overshoot
    // as "done" keeps a corrupted count from stalling the scan forever.
    assign settle_done_s = hit_s || (cnt_s > dwell_q_r);

`ifdef MUX_SCAN_CONT_EN
    assign repeat_s = cont;
`else
    assign repeat_s = 1'b0;
`endif

    // Counter control: clear on scan start and on every capture, count in SETTLE.
    always_comb begin
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_clear_s = start;
            end
            SETTLE: begin
                cnt_enable_s = !settle_done_s;
            end
            CAPTURE: begin
                cnt_clear_s = 1'b1;
            end
            default: begin
                cnt_clear_s = 1'b1;
            end
        endcase
    end

    // Shadow vector with the current channel's bit replaced by the live mux bit.
    always_comb begin
        capture_vec_s      = shadow_r;
        capture_vec_s[sel] = mux_out;
    end

    // Scan FSM with registered select, sample vector, valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sel        <= '0;
            sample_vec <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            shadow_r   <= '0;
            dwell_q_r  <= '0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    sel <= '0;
                    if (start) begin
                        dwell_q_r <= dwell;
                        shadow_r  <= '0;
                        busy      <= 1'b1;
                        state_r   <= SETTLE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_done_s) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                CAPTURE: begin
                    shadow_r <= capture_vec_s;
                    if (sel != LAST_SEL) begin
                        sel     <= sel + SEL_ONE;
                        state_r <= SETTLE;
                    end else begin
                        sample_vec <= capture_vec_s;
                        valid      <= 1'b1;
                        sel        <= '0;
                        if (repeat_s) begin
                            // Next frame starts immediately; busy stays high.
                            shadow_r  <= '0;
                            dwell_q_r <= dwell;
                            state_r   <= SETTLE;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    sel      <= '0;
                    busy     <= 1'b0;
                    shadow_r <= '0;
                end
            endcase
        end
    end

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Directed bench for mux_scan_ctrl. A behavioural 4:1 mux feeds mux_out from
// the bench-driven input field. Expected sample vectors are queued when a scan
// is launched and compared whenever the DUT pulses valid.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dwell;
    logic       mux_out;
    logic [1:0] sel;
    logic [3:0] sample_vec;
    logic       valid;
    logic       busy;
    logic [3:0] in_bits;
`ifdef MUX_SCAN_CONT_EN
    logic       cont;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    mux_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dwell      (dwell),
        .mux_out    (mux_out),
`ifdef MUX_SCAN_CONT_EN
        .cont       (cont),
`endif
        .sel        (sel),
        .sample_vec (sample_vec),
        .valid      (valid),
        .busy       (busy)
    );

    // Downstream 4:1 bit mux.
    assign mux_out = in_bits[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid observed=%b required=no_pulse", sample_vec);
            end
            if (exp_q.size() != 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                total++;
                assert (sample_vec === e) else begin
                    bad++;
                    $error("FAIL sample_vec observed=%b required=%b", sample_vec, e);
                end
            end
        end
    end

    // One-shot scan: sel holds each channel dwell+2 cycles, valid after
    // 4*(dwell+2) edges from the accepting edge. dwell is changed to dw_mid
    // at cycle 3 of the scan, which must not alter the timing.
    task automatic run_scan(input logic [3:0] pat, input logic [3:0] dw,
                            input logic [3:0] dw_mid, input logic [3:0] exp_vec);
        int lat;
        lat = 4 * (int'(dw) + 2);
        chk("idle_busy", 32'(busy), 32'(0));
        in_bits = pat;
        dwell   = dw;
        start   = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(exp_vec);
        for (int k = 0; k < lat; k++) begin
            chk("scan_sel", 32'(sel), 32'(k / (int'(dw) + 2)));
            chk("scan_busy", 32'(busy), 32'(1));
            chk("scan_novalid", 32'(valid), 32'(0));
            if (k == 3) dwell = dw_mid;
            tick();
        end
        chk("end_valid", 32'(valid), 32'(1));
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_sel", 32'(sel), 32'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        dwell   = 4'd0;
        in_bits = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
        cont    = 1'b0;
`endif
        tick();
        tick();
        chk("rst_sel", 32'(sel), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_vec", 32'(sample_vec), 32'(0));
        rst_n = 1'b1;
        tick();

        // 1. Reset in the middle of channel 2 (dwell=3: channel 2 spans cycles 10..14).
        in_bits = 4'b0110;
        dwell   = 4'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(4'b0110);
        for (int k = 0; k < 11; k++) tick();
        chk("mid_sel", 32'(sel), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(sel), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_valid", 32'(valid), 32'(0));
        chk("async_vec", 32'(sample_vec), 32'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_vec", 32'(sample_vec), 32'(0));

        // 2. dwell=0: 8-cycle scan.
        run_scan(4'b1010, 4'd0, 4'd0, 4'b1010);
        tick();
        chk("hold_vec", 32'(sample_vec), 32'(4'b1010));

        // 3. dwell=5: 28-cycle scan.
        run_scan(4'b1101, 4'd5, 4'd5, 4'b1101);
        tick();

        // 4. start held high; in switches while channel 1 is still settling,
        //    so only channel 0 is read from 1010 and channels 1..3 from 0101.
        in_bits = 4'b1010;
        dwell   = 4'd0;
        start   = 1'b1;
        tick();
        exp_q.push_back(4'b0100);
        for (int k = 0; k < 8; k++) begin
            chk("t4a_sel", 32'(sel), 32'(k / 2));
            chk("t4a_busy", 32'(busy), 32'(1));
            if (k == 2) in_bits = 4'b0101;
            tick();
        end
        chk("t4a_valid", 32'(valid), 32'(1));
        chk("t4a_idle", 32'(busy), 32'(0));
        exp_q.push_back(4'b0101);
        tick();
        // start was still high in the valid cycle: a new scan is running.
        for (int k = 0; k < 8; k++) begin
            chk("t4b_sel", 32'(sel), 32'(k / 2));
            chk("t4b_busy", 32'(busy), 32'(1));
            tick();
        end
        chk("t4b_valid", 32'(valid), 32'(1));
        start = 1'b0;
        tick();
        chk("t4_stop", 32'(busy), 32'(0));

        // 5. dwell changed mid-scan is ignored; next scan uses 7 (36 cycles).
        run_scan(4'b1001, 4'd0, 4'd7, 4'b1001);
        run_scan(4'b0110, 4'd7, 4'd7, 4'b0110);
        tick();

`ifdef MUX_SCAN_CONT_EN
        // 6. Continuous frames every 12 cycles; cont dropped in the third frame.
        in_bits = 4'b0011;
        dwell   = 4'd1;
        cont    = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(4'b0011);
            for (int k = 0; k < 12; k++) begin
                chk("cont_valid", 32'(valid), 32'((k == 0 && f > 0) ? 1 : 0));
                chk("cont_busy", 32'(busy), 32'(1));
                chk("cont_sel", 32'(sel), 32'(k / 3));
                if (f == 2 && k == 0) cont = 1'b0;
                tick();
            end
        end
        chk("cont_last_valid", 32'(valid), 32'(1));
        chk("cont_last_busy", 32'(busy), 32'(0));
        for (int k = 0; k < 20; k++) tick();
        chk("cont_idle", 32'(busy), 32'(0));
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
